// File: rtl/cba_seq_adder.sv
// cba_seq_adder: multi-cycle wide adder/subtractor.
// Operands are 16*WORDS bits wide. The block works through them one 16-bit slice per
// clock, least-significant slice first, using one shared 16-bit carry-bypass adder.
// The carry between slices is held in a register.
//
// State table:
//   state | meaning
//   IDLE  | waiting for an operation; in_ready=1
//   RUN   | processing slice cnt; carry holds the carry into that slice
//   DONE  | result valid; held until out_ready
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    request handshake carrying in_a, in_b, in_sub (0: A+B, 1: A-B)
//   out_valid/out_ready  result handshake carrying out_sum, out_cout, out_ovf
//   busy                 high while in RUN or DONE
module cba_seq_adder #(
    parameter int WORDS = 4,
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in_a,
    input  logic [16*WORDS-1:0]   in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int W = 16 * WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [W-1:0]       a_q, b_q;
    logic               sub_q;
    logic [W-1:0]       sum_q;
    logic               cout_q, ovf_q;

    logic [15:0]        a_sl, b_sl, s_sl;
    logic               c15, c_out;
    logic               last;

    assign last = (cnt == CNT_W'(WORDS - 1));

    // Slice operand select; B is inverted for subtraction (carry-in supplies the +1).
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (cnt == CNT_W'(w)) begin
                a_sl = a_q[16*w +: 16];
                b_sl = b_q[16*w +: 16] ^ {16{sub_q}};
            end
        end
    end

    // 16-bit carry-bypass adder: two 8-bit ripple groups. When every bit in a group
    // propagates, the group carry-out is taken straight from its carry-in.
    // c15 is the ripple carry into bit 15, needed for signed overflow.
    always_comb begin
        logic rc, p, cin_g, grp_c;
        s_sl  = '0;
        c15   = 1'b0;
        rc    = 1'b0;
        p     = 1'b0;
        cin_g = 1'b0;
        grp_c = carry;
        for (int g = 0; g < 2; g++) begin
            cin_g = grp_c;
            rc    = cin_g;
            p     = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (8*g + k == 15) c15 = rc;
                s_sl[8*g+k] = a_sl[8*g+k] ^ b_sl[8*g+k] ^ rc;
                rc = (a_sl[8*g+k] & b_sl[8*g+k]) | (rc & (a_sl[8*g+k] ^ b_sl[8*g+k]));
                p  = p & (a_sl[8*g+k] ^ b_sl[8*g+k]);
            end
            grp_c = p ? cin_g : rc;
        end
        c_out = grp_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= in_a;
                        b_q    <= in_b;
                        sub_q  <= in_sub;
                        carry  <= in_sub;
                        cnt    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (cnt == CNT_W'(w)) sum_q[16*w +: 16] <= s_sl;
                    end
                    carry <= c_out;
                    if (last) begin
                        cout_q <= c_out;
                        ovf_q  <= c15 ^ c_out;
                        cnt    <= '0;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
